// File: rtl/xfer_tx_queue.sv
// xfer_tx_queue: circular-buffer byte queue feeding a flag/busy handshake crossing stage.
// One entry is sent per round trip: flag pulse, busy rises (ack), busy falls (done).
module xfer_tx_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     flag_out,
  output logic [WIDTH-1:0]         bus_out,
  input  logic                     busy_in
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q;
  logic [WIDTH-1:0] bus_q;
  logic             push, pop;
  // full is judged before any same-cycle pop, so a push into a full queue drops
  assign full     = count_q == (AW+1)'(DEPTH);
  assign empty    = count_q == '0;
  assign push     = wr_en && !full;
  assign pop      = flag_out;
  assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign bus_out  = bus_q;
  always_comb begin
    state_d  = state_q;
    flag_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        flag_out = !empty && !busy_in;
        state_d  = flag_out ? WAIT_ACK : IDLE;
      end
      WAIT_ACK:  state_d = busy_in ? WAIT_DONE : WAIT_ACK;
      WAIT_DONE: state_d = busy_in ? WAIT_DONE : IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_q || (wr_en && full);
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        bus_q    <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_xfer_tx_queue.sv
// tb_xfer_tx_queue: directed scenarios plus random traffic against a queue-based model.
// A monitor compares every cycle; the busy_in process emulates the crossing stage.
module tb_xfer_tx_queue;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic             busy_in = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             full, empty, overflow, flag_out;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] bus_out;
  int checks = 0;
  int errors = 0;
  int busy_mode = 2;
  int cyc_n = 0;
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] exp_bus = '0;
  bit exp_ov = 0;
  int phase = 0;
  bit armed = 0;
  bit prev_flag = 0;
  int flag_times[$];

  xfer_tx_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .flag_out(flag_out), .bus_out(bus_out), .busy_in(busy_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
    end
  endtask

  // Model: mq is the queue content, phase tracks the handshake (0 idle, 1 await ack, 2 await done)
  always @(negedge clk) begin
    bit ef;
    bit fm;
    cyc_n++;
    if (armed) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("overflow", 32'(overflow), 32'(exp_ov));
      chk("bus_out", 32'(bus_out), 32'(exp_bus));
    end
    ef = armed && phase == 0 && mq.size() != 0 && !busy_in;
    if (armed && !reset) begin
      chk("flag_out", 32'(flag_out), 32'(ef));
      if (flag_out === 1'b1) begin
        chk("flag_back_to_back", 32'(prev_flag), 0);
        chk("flag_while_busy", 32'(busy_in), 0);
        flag_times.push_back(cyc_n);
      end
    end
    prev_flag = flag_out === 1'b1;
    if (reset) begin
      mq.delete();
      exp_bus = '0;
      exp_ov  = 0;
      phase   = 0;
      armed   = 1;
    end else if (armed) begin
      fm = mq.size() == DEPTH;
      if (wr_en && fm) exp_ov = 1;
      if (phase == 0 && ef) begin
        exp_bus = mq.pop_front();
        phase = 1;
      end else if (phase == 1 && busy_in) phase = 2;
      else if (phase == 2 && !busy_in) phase = 0;
      if (wr_en && !fm) mq.push_back(wr_data);
    end
  end

  // Crossing-stage model: busy rises the cycle after a flag and stays high for a set time
  initial begin
    int cnt;
    bit f;
    cnt = 0;
    forever begin
      @(negedge clk);
      f = flag_out === 1'b1;
      @(posedge clk);
      #1;
      if (cnt > 0) cnt--;
      if (f) cnt = (busy_mode == 3) ? int'($urandom_range(1, 6)) : 6;
      busy_in = busy_mode == 1 || (busy_mode >= 2 && cnt > 0);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    wr_en = 1'b1;
    wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    wr_en = 1'b0;
    while ((mq.size() != 0 || phase != 0) && t < 400) begin
      cyc();
      t++;
    end
    chk(nm, 32'(t < 400), 1);
    chk({nm, "_empty"}, 32'(empty), 1);
  endtask

  initial begin
    int t;
    busy_mode = 2;
    cyc(3);
    reset = 1'b0;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_flag", 32'(flag_out), 0);
    push(8'hA5);
    chk("a5_flag_next_cycle", 32'(flag_out), 1);
    cyc(3);
    chk("a5_bus", 32'(bus_out), 32'hA5);
    drain("a5_drain");
    chk("a5_bus_held", 32'(bus_out), 32'hA5);
    flag_times.delete();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    drain("seq_drain");
    chk("seq_flag_count", 32'(flag_times.size()), 3);
    if (flag_times.size() == 3)
      for (int i = 1; i < 3; i++)
        chk("seq_flag_gap_ge8", 32'((flag_times[i] - flag_times[i-1]) >= 8), 1);
    chk("seq_last_bus", 32'(bus_out), 32'h03);
    busy_mode = 1;
    cyc(2);
    for (int i = 0; i < DEPTH + 1; i++) push(WIDTH'(8'h10 + i));
    chk("ovf_full", 32'(full), 1);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_flag", 32'(overflow), 1);
    busy_mode = 2;
    drain("ovf_drain");
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ovf_last_sent", 32'(bus_out), 32'h17);
    do_reset();
    busy_mode = 1;
    cyc(2);
    for (int i = 0; i < 3; i++) push(WIDTH'(8'h20 + i));
    chk("sim_pre_count", 32'(count), 3);
    busy_mode = 2;
    t = 0;
    while (flag_out !== 1'b1 && t < 20) begin
      cyc();
      t++;
    end
    chk("sim_flag_seen", 32'(flag_out), 1);
    chk("sim_count_before", 32'(count), 3);
    push(8'h23);
    chk("sim_count_after", 32'(count), 3);
    for (int i = 4; i < 20; i++) begin
      push(WIDTH'(8'h20 + i));
      cyc(7);
    end
    drain("wrap_drain");
    chk("wrap_last_sent", 32'(bus_out), 32'h33);
    do_reset();
    busy_mode = 2;
    for (int i = 0; i < 5; i++) push(WIDTH'(8'h40 + i));
    t = 0;
    while (busy_in !== 1'b1 && t < 20) begin
      cyc();
      t++;
    end
    cyc(2);
    chk("wd_busy", 32'(busy_in), 1);
    chk("wd_count", 32'(count), 4);
    busy_mode = 1;
    do_reset();
    chk("wd_rst_count", 32'(count), 0);
    chk("wd_rst_empty", 32'(empty), 1);
    chk("wd_rst_full", 32'(full), 0);
    chk("wd_rst_overflow", 32'(overflow), 0);
    chk("wd_rst_flag", 32'(flag_out), 0);
    chk("wd_rst_bus", 32'(bus_out), 0);
    push(8'h55);
    cyc(4);
    chk("wd_no_flag_busy", 32'(flag_out), 0);
    chk("wd_pending", 32'(count), 1);
    busy_mode = 2;
    drain("wd_drain");
    chk("wd_sent", 32'(bus_out), 32'h55);
    do_reset();
    busy_mode = 3;
    for (int i = 0; i < 1000; i++) begin
      wr_en = $urandom_range(0, (i < 500) ? 3 : 11) == 0;
      wr_data = WIDTH'($urandom);
      cyc();
    end
    wr_en = 1'b0;
    drain("rand_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
